// File: rtl/bin2bcd_seq_if.sv
// Start/ready request and registered result bundle for the sequential binary-to-BCD converter.
interface bin2bcd_seq_if #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
);
    logic                  start;
    logic [WIDTH-1:0]      in;
    logic                  ready;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, in,
        input  ready, done, overflow, bcd, blank
    );

    modport slave (
        input  start, in,
        output ready, done, overflow, bcd, blank
    );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter with saturation on overflow
// and a leading-zero blanking mask; results update only when a conversion completes.
module bin2bcd_seq #(
    parameter int unsigned WIDTH  = 14,
    parameter int unsigned DIGITS = 4
) (
    input logic          clk,
    input logic          reset,
    bin2bcd_seq_if.slave bus
);
    localparam int unsigned CntW = $clog2(WIDTH + 1);
    localparam int unsigned BcdW = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BlankRst = {DIGITS{1'b1}} << 1;

    typedef enum logic [0:0] {StIdle, StConvert} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic [BcdW-1:0]   digits_q, digits_d;
    logic [BcdW-1:0]   digits_adj, digits_shift;
    logic              sticky_q, sticky_d, sticky_shift;
    logic [CntW-1:0]   count_q, count_d;
    logic              last_shift, accept, finish;
    logic [BcdW-1:0]   bcd_q, bcd_d;
    logic              overflow_q, overflow_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              done_q, done_d;

    // State register and all datapath/result flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            shreg_q    <= '0;
            digits_q   <= '0;
            sticky_q   <= 1'b0;
            count_q    <= '0;
            bcd_q      <= '0;
            overflow_q <= 1'b0;
            blank_q    <= BlankRst;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            digits_q   <= digits_d;
            sticky_q   <= sticky_d;
            count_q    <= count_d;
            bcd_q      <= bcd_d;
            overflow_q <= overflow_d;
            blank_q    <= blank_d;
            done_q     <= done_d;
        end
    end

    // One shift-and-add-3 step; a set MSB in the adjusted top digit means the
    // running value has reached 10^DIGITS.
    always_comb begin
        digits_adj = digits_q;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (digits_q[4*i +: 4] > 4'd4) begin
                digits_adj[4*i +: 4] = digits_q[4*i +: 4] + 4'd3;
            end
        end
        digits_shift = {digits_adj[BcdW-2:0], shreg_q[WIDTH-1]};
        sticky_shift = sticky_q | digits_adj[BcdW-1];
        last_shift   = (count_q == CntW'(WIDTH - 1));
        accept       = (state_q == StIdle) && bus.start;
        finish       = (state_q == StConvert) && last_shift;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:    if (bus.start) state_d = StConvert;
            StConvert: if (last_shift) state_d = StIdle;
            default:   state_d = StIdle;
        endcase
    end

    // Working registers and result registers.
    always_comb begin
        logic zero_above;
        shreg_d    = shreg_q;
        digits_d   = digits_q;
        sticky_d   = sticky_q;
        count_d    = count_q;
        bcd_d      = bcd_q;
        overflow_d = overflow_q;
        blank_d    = blank_q;
        done_d     = finish;
        zero_above = 1'b1;

        if (accept) begin
            shreg_d  = bus.in;
            digits_d = '0;
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (state_q == StConvert) begin
            shreg_d  = shreg_q << 1;
            digits_d = digits_shift;
            sticky_d = sticky_shift;
            count_d  = count_q + CntW'(1);
        end

        if (finish) begin
            overflow_d = sticky_shift;
            bcd_d      = sticky_shift ? {DIGITS{4'h9}} : digits_shift;
            blank_d[0] = 1'b0;
            for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
                zero_above = zero_above & (bcd_d[4*i +: 4] == 4'd0);
                blank_d[i] = zero_above;
            end
        end
    end

    // Outputs come straight from flops.
    always_comb begin
        bus.ready    = (state_q == StIdle);
        bus.done     = done_q;
        bus.overflow = overflow_q;
        bus.bcd      = bcd_q;
        bus.blank    = blank_q;
    end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: table-driven vectors through a scoreboard,
// plus streaming, mid-conversion reset and an 8-bit/2-digit instance.
module tb_bin2bcd_seq;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    bin2bcd_seq_if #(.WIDTH(14), .DIGITS(4)) bus14();
    bin2bcd_seq_if #(.WIDTH(8),  .DIGITS(2)) bus8();

    bin2bcd_seq #(.WIDTH(14), .DIGITS(4)) dut (.clk(clk), .reset(reset), .bus(bus14));
    bin2bcd_seq #(.WIDTH(8),  .DIGITS(2)) dut8 (.clk(clk), .reset(reset), .bus(bus8));

    typedef struct {
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
        int          acc;
    } exp_t;

    typedef struct {
        int unsigned value;
        logic [15:0] bcd;
        logic        ovf;
        logic [3:0]  blank;
    } vec_t;

    exp_t q14[$];
    exp_t q8[$];
    exp_t cur14;
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   dones14 = 0;
    int   last_acc14 = -1;
    bit   stream_mode = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by division, saturated when out of range.
    function automatic exp_t model(input int unsigned v, input int d);
        exp_t        e;
        int unsigned lim = 1;
        int unsigned t = v;
        bit          z = 1'b1;
        for (int i = 0; i < d; i++) lim = lim * 10;
        e.ovf = (v >= lim);
        e.bcd = '0;
        e.blank = '0;
        e.acc = 0;
        for (int i = 0; i < d; i++) begin
            e.bcd[4*i +: 4] = e.ovf ? 4'd9 : 4'(t % 10);
            t = t / 10;
        end
        for (int i = d - 1; i >= 1; i--) begin
            z = z && (e.bcd[4*i +: 4] == 4'd0);
            e.blank[i] = z;
        end
        return e;
    endfunction

    initial forever @(posedge clk) cyc++;

    // Scoreboard for the 14-bit instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus14.done) begin
                    dones14++;
                    if (q14.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done14_unexpected: got done with empty scoreboard, cycle %0d",
                                 cyc);
                    end else begin
                        e = q14.pop_front();
                        chk("bcd14", 32'(bus14.bcd), 32'(e.bcd));
                        chk("ovf14", 32'(bus14.overflow), 32'(e.ovf));
                        chk("blank14", 32'(bus14.blank), 32'(e.blank));
                        chk("latency14", 32'(cyc - e.acc), 32'd14);
                        chk("ready_with_done14", 32'(bus14.ready), 32'd1);
                    end
                end else if (q14.size() > 0) begin
                    chk("ready14_busy", 32'(bus14.ready), 32'd0);
                end
                if (bus14.start && bus14.ready) begin
                    e = stream_mode ? model(32'(bus14.in), 4) : cur14;
                    e.acc = cyc + 1;
                    if (stream_mode && last_acc14 >= 0)
                        chk("spacing14", 32'(cyc + 1 - last_acc14), 32'd15);
                    last_acc14 = cyc + 1;
                    q14.push_back(e);
                end
            end
        end
    end

    // Scoreboard for the 8-bit instance.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (bus8.done) begin
                    if (q8.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL done8_unexpected: got done with empty scoreboard, cycle %0d",
                                 cyc);
                    end else begin
                        e = q8.pop_front();
                        chk("bcd8", 32'(bus8.bcd), 32'(e.bcd[7:0]));
                        chk("ovf8", 32'(bus8.overflow), 32'(e.ovf));
                        chk("blank8", 32'(bus8.blank), 32'(e.blank[1:0]));
                        chk("latency8", 32'(cyc - e.acc), 32'd8);
                    end
                end
                if (bus8.start && bus8.ready) begin
                    e = model(32'(bus8.in), 2);
                    e.acc = cyc + 1;
                    q8.push_back(e);
                end
            end
        end
    end

    task automatic wait_idle14();
        for (int i = 0; i < 60 && q14.size() != 0; i++) @(negedge clk);
        if (q14.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout14: %0d results still pending, want 0", q14.size());
            q14.delete();
        end
    endtask

    task automatic wait_idle8();
        for (int i = 0; i < 40 && q8.size() != 0; i++) @(negedge clk);
        if (q8.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout8: %0d results still pending, want 0", q8.size());
            q8.delete();
        end
    endtask

    task automatic run14(input int unsigned v, input exp_t e);
        @(posedge clk);
        #1;
        cur14 = e;
        bus14.in = 14'(v);
        bus14.start = 1'b1;
        @(posedge clk);
        #1;
        bus14.start = 1'b0;
        wait_idle14();
    endtask

    task automatic run8(input int unsigned v);
        @(posedge clk);
        #1;
        bus8.in = 8'(v);
        bus8.start = 1'b1;
        @(posedge clk);
        #1;
        bus8.start = 1'b0;
        wait_idle8();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs[10];
        exp_t e;
        int   d0;

        vecs[0] = '{9999,  16'h9999, 1'b0, 4'b0000};
        vecs[1] = '{0,     16'h0000, 1'b0, 4'b1110};
        vecs[2] = '{305,   16'h0305, 1'b0, 4'b1000};
        vecs[3] = '{10000, 16'h9999, 1'b1, 4'b0000};
        vecs[4] = '{16383, 16'h9999, 1'b1, 4'b0000};
        vecs[5] = '{42,    16'h0042, 1'b0, 4'b1100};
        vecs[6] = '{1,     16'h0001, 1'b0, 4'b1110};
        vecs[7] = '{1000,  16'h1000, 1'b0, 4'b0000};
        vecs[8] = '{99,    16'h0099, 1'b0, 4'b1100};
        vecs[9] = '{16383, 16'h9999, 1'b1, 4'b0000};

        reset = 1'b1;
        bus14.start = 1'b0;
        bus14.in = '0;
        bus8.start = 1'b0;
        bus8.in = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(bus14.ready), 32'd1);
        chk("rst_done", 32'(bus14.done), 32'd0);
        chk("rst_ovf", 32'(bus14.overflow), 32'd0);
        chk("rst_bcd", 32'(bus14.bcd), 32'h0);
        chk("rst_blank", 32'(bus14.blank), 32'b1110);
        chk("rst_blank8", 32'(bus8.blank), 32'b10);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            e.bcd = vecs[i].bcd;
            e.ovf = vecs[i].ovf;
            e.blank = vecs[i].blank;
            e.acc = 0;
            run14(vecs[i].value, e);
            repeat (3) @(negedge clk);
            chk("hold_bcd", 32'(bus14.bcd), 32'(vecs[i].bcd));
            chk("hold_done_low", 32'(bus14.done), 32'd0);
        end

        // Reset seven cycles into a conversion of 1234.
        @(posedge clk);
        #1;
        cur14 = '{16'h1234, 1'b0, 4'b0000, 0};
        bus14.in = 14'd1234;
        bus14.start = 1'b1;
        @(posedge clk);
        #1;
        bus14.start = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        d0 = dones14;
        reset = 1'b1;
        q14.delete();
        #1;
        chk("midrst_ready", 32'(bus14.ready), 32'd1);
        chk("midrst_done", 32'(bus14.done), 32'd0);
        chk("midrst_ovf", 32'(bus14.overflow), 32'd0);
        chk("midrst_bcd", 32'(bus14.bcd), 32'h0);
        chk("midrst_blank", 32'(bus14.blank), 32'b1110);
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("midrst_no_done", 32'(dones14), 32'(d0));
        run14(1234, '{16'h1234, 1'b0, 4'b0000, 0});

        // start held high with in changing every cycle.
        stream_mode = 1'b1;
        last_acc14 = -1;
        d0 = dones14;
        @(posedge clk);
        #1;
        bus14.start = 1'b1;
        for (int i = 0; i < 75; i++) begin
            bus14.in = 14'($urandom_range(0, 16383));
            @(posedge clk);
            #1;
        end
        bus14.start = 1'b0;
        wait_idle14();
        stream_mode = 1'b0;
        chk("stream_count", 32'(dones14 - d0), 32'd5);

        run8(99);
        run8(255);
        run8(0);
        run8(7);
        run8(100);
        run8(42);

        chk("q14_empty", 32'(q14.size()), 32'd0);
        chk("q8_empty", 32'(q8.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
